// File: rtl/poke_pkg.sv
// Shared definitions for the creature-evolution controller.
//   state_t     : FSM state encoding, also the value driven on the 2-bit
//                 state output (IDLE=0, CHARGE=1, EVOLVING=2, FINAL=3).
//   DEF_THRESH  : default loudness threshold.
//   cnt_w()     : bit width of a counter that must reach n-1. The result
//                 is never less than 1.
package poke_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CHARGE   = 2'd1,
        ST_EVOLVING = 2'd2,
        ST_FINAL    = 2'd3
    } state_t;

    localparam int DEF_THRESH = 10;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/evolve_timer.sv
// Evolution duration timer.
// The count runs while en is high. done is high during the cycle in which
// count == CYCLES-1 and en is high. On the following edge the count
// returns to zero.
// Ports:
//   clk  in  1 : system clock
//   clr  in  1 : synchronous clear; overrides en
//   en   in  1 : count enable
//   done out 1 : last cycle of the timed interval
module evolve_timer
    import poke_pkg::*;
#(
    parameter int CYCLES = 100000000
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int           W    = cnt_w(CYCLES);
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] count;

    assign done = en && (count == LAST);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= done ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/poke_evolve_fsm.sv
// Creature-evolution controller driven by the microphone volume level.
// A run of HOLD_CYCLES consecutive loud samples starts an evolution.
// A sample is loud when vol > THRESH. An evolution lasts EVOLVE_CYCLES
// clocks and then advances the creature by one stage. When the creature
// reaches stage N_STAGES-1, the controller enters FINAL and stays there
// until clr.
// Ports:
//   clk          in  1       : system clock
//   clr          in  1       : synchronous active-high reset, highest priority
//   vol          in  VOL_W   : current volume level (unsigned)
//   state        out 2       : FSM state (IDLE=0, CHARGE=1, EVOLVING=2, FINAL=3)
//   stage        out STAGE_W : current creature stage
//   evolving     out 1       : high while state is EVOLVING
//   evolve_pulse out 1       : one-cycle strobe on the cycle stage increments
module poke_evolve_fsm
    import poke_pkg::*;
#(
    parameter int VOL_W         = 4,
    parameter int THRESH        = DEF_THRESH,
    parameter int HOLD_CYCLES   = 4,
    parameter int EVOLVE_CYCLES = 100000000,
    parameter int N_STAGES      = 3,
    parameter int STAGE_W       = $clog2(N_STAGES)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [VOL_W-1:0]   vol,
    output logic [1:0]         state,
    output logic [STAGE_W-1:0] stage,
    output logic               evolving,
    output logic               evolve_pulse
);

    localparam int                 HOLD_W     = cnt_w(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [VOL_W-1:0]   THRESH_V   = VOL_W'(THRESH);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(N_STAGES - 1);

    state_t              state_q;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [STAGE_W-1:0]  stage_next;
    logic                loud;
    logic                enter_evolving;
    logic                timer_done;

    assign loud       = (vol > THRESH_V);
    assign stage_next = stage + 1'b1;

    // The last loud sample of a run moves the FSM into EVOLVING. With
    // HOLD_CYCLES == 1, the first loud sample in IDLE is the last sample.
    assign enter_evolving = loud &&
        (((state_q == ST_IDLE) && (HOLD_CYCLES == 1)) ||
         ((state_q == ST_CHARGE) && (hold_cnt == HOLD_LAST)));

    // The timer is cleared when the FSM enters EVOLVING, so every
    // evolution lasts the full EVOLVE_CYCLES.
    evolve_timer #(
        .CYCLES (EVOLVE_CYCLES)
    ) u_timer (
        .clk  (clk),
        .clr  (clr | enter_evolving),
        .en   (state_q == ST_EVOLVING),
        .done (timer_done)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            stage        <= '0;
            evolving     <= 1'b0;
            evolve_pulse <= 1'b0;
            hold_cnt     <= '0;
        end else begin
            evolve_pulse <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enter_evolving) begin
                        state_q  <= ST_EVOLVING;
                        evolving <= 1'b1;
                    end else if (loud) begin
                        state_q  <= ST_CHARGE;
                        hold_cnt <= HOLD_W'(1);
                    end
                end
                ST_CHARGE: begin
                    if (!loud) begin
                        // A quiet sample cancels the whole run of loud samples.
                        state_q  <= ST_IDLE;
                        hold_cnt <= '0;
                    end else if (enter_evolving) begin
                        state_q  <= ST_EVOLVING;
                        evolving <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_EVOLVING: begin
                    if (timer_done) begin
                        stage        <= stage_next;
                        evolve_pulse <= 1'b1;
                        evolving     <= 1'b0;
                        state_q      <= (stage_next == STAGE_LAST) ? ST_FINAL : ST_IDLE;
                    end
                end
                ST_FINAL: begin
                    // FINAL holds until clr. Because nothing leaves this
                    // state, stage cannot advance past STAGE_LAST.
                end
                default: begin
                    state_q  <= ST_IDLE;
                    evolving <= 1'b0;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_poke_evolve_fsm.sv
// Directed bench for poke_evolve_fsm.
// The main instance uses HOLD_CYCLES=3, EVOLVE_CYCLES=5 and N_STAGES=3.
// A second instance uses HOLD_CYCLES=1 and EVOLVE_CYCLES=1.
module tb_poke_evolve_fsm;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr,   clr_c;
    logic [3:0] vol,   vol_c;
    logic [1:0] state, state_c;
    logic [1:0] stage, stage_c;
    logic       evolving, evolving_c;
    logic       evolve_pulse, evolve_pulse_c;

    poke_evolve_fsm #(
        .VOL_W(4), .THRESH(10), .HOLD_CYCLES(3), .EVOLVE_CYCLES(5), .N_STAGES(3), .STAGE_W(2)
    ) dut (
        .clk(clk), .clr(clr), .vol(vol), .state(state), .stage(stage),
        .evolving(evolving), .evolve_pulse(evolve_pulse)
    );

    poke_evolve_fsm #(
        .VOL_W(4), .THRESH(10), .HOLD_CYCLES(1), .EVOLVE_CYCLES(1), .N_STAGES(3), .STAGE_W(2)
    ) dut_c (
        .clk(clk), .clr(clr_c), .vol(vol_c), .state(state_c), .stage(stage_c),
        .evolving(evolving_c), .evolve_pulse(evolve_pulse_c)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic       clr;
        logic [3:0] vol;
        logic [1:0] st;
        logic [1:0] stg;
        logic       ev;
        logic       pl;
    } vec_t;

    vec_t vecs[$];
    logic [1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    function automatic void add(input logic c, input logic [3:0] v, input logic [1:0] st,
                                input logic [1:0] stg, input logic ev, input logic pl);
        vec_t r;
        r.clr = c; r.vol = v; r.st = st; r.stg = stg; r.ev = ev; r.pl = pl;
        vecs.push_back(r);
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    initial begin
        int  n_ev;
        bit  got;
        clr = 1'b1; vol = '0; clr_c = 1'b1; vol_c = '0;

        // reset held two cycles with loud input, then one quiet cycle
        add(1, 15, 0, 0, 0, 0); add(1, 15, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        // threshold edge: vol == THRESH is not loud
        for (int i = 0; i < 20; i++) add(0, 10, 0, 0, 0, 0);
        // vol = 11 three times enters EVOLVING, followed by a full evolution
        add(0, 11, 1, 0, 0, 0); add(0, 11, 1, 0, 0, 0); add(0, 11, 2, 0, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 2, 0, 1, 0);
        add(0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 1, 0, 0);
        // charge abort 12,12,5,12,12,12; the evolution ignores vol
        add(0, 12, 1, 1, 0, 0); add(0, 12, 1, 1, 0, 0); add(0, 5, 0, 1, 0, 0);
        add(0, 12, 1, 1, 0, 0); add(0, 12, 1, 1, 0, 0); add(0, 12, 2, 1, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 15, 2, 1, 1, 0);
        add(0, 15, 3, 2, 0, 1);
        // FINAL is absorbing under loud input
        for (int i = 0; i < 50; i++) add(0, 15, 3, 2, 0, 0);
        // reset while in FINAL
        add(1, 15, 0, 0, 0, 0);
        // reset in the third EVOLVING cycle
        add(0, 15, 1, 0, 0, 0); add(0, 15, 1, 0, 0, 0); add(0, 15, 2, 0, 1, 0);
        add(0, 0, 2, 0, 1, 0); add(0, 0, 2, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            clr = vecs[i].clr;
            vol = vecs[i].vol;
            tick();
            n_vec++;
            if ({state, stage, evolving, evolve_pulse} !=
                {vecs[i].st, vecs[i].stg, vecs[i].ev, vecs[i].pl}) begin
                n_err++;
                $display("FAIL vec%0d: got st=%0d stg=%0d ev=%0d pl=%0d expected st=%0d stg=%0d ev=%0d pl=%0d",
                         i, state, stage, evolving, evolve_pulse,
                         vecs[i].st, vecs[i].stg, vecs[i].ev, vecs[i].pl);
            end
        end

        // after the mid-evolution reset, a new evolution lasts the full 5 cycles
        clr = 1'b0;
        vol = 4'd12; tick(); chk("retry_charge1", state, 1);
        tick();                chk("retry_charge2", state, 1);
        tick();                chk("retry_enter", state, 2);
        exp_q.push_back(2'd1);
        vol = 4'd0;
        n_ev = evolving ? 1 : 0;
        got  = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            if (evolving) n_ev++;
            if (evolve_pulse) got = 1'b1;
        end
        chk("retry_pulse_seen", int'(got), 1);
        chk("retry_evolving_len", n_ev, 5);
        chk("retry_stage", stage, exp_q.pop_front());
        chk("retry_state", state, 0);
        tick();
        chk("retry_pulse_once", evolve_pulse, 0);

        // instance with HOLD_CYCLES=1 and EVOLVE_CYCLES=1
        clr_c = 1'b1; tick();
        chk("c_reset_state", state_c, 0);
        clr_c = 1'b0; vol_c = 4'd15; tick();
        chk("c_enter_state", state_c, 2);
        chk("c_enter_evolving", evolving_c, 1);
        chk("c_enter_stage", stage_c, 0);
        vol_c = 4'd0; tick();
        chk("c_done_state", state_c, 0);
        chk("c_done_stage", stage_c, 1);
        chk("c_done_pulse", evolve_pulse_c, 1);
        chk("c_done_evolving", evolving_c, 0);
        tick();
        chk("c_pulse_clear", evolve_pulse_c, 0);
        vol_c = 4'd15; tick();
        chk("c_enter2_state", state_c, 2);
        vol_c = 4'd15; tick();
        chk("c_final_state", state_c, 3);
        chk("c_final_stage", stage_c, 2);
        tick();
        chk("c_final_hold", {state_c, stage_c, evolve_pulse_c}, {2'd3, 2'd2, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
